mmio_bus_fabric: RTL



---
 rtl/bus_pkg.sv | 24 ++
 rtl/mmio_addr_decode.sv | 22 ++
 rtl/mmio_bus_fabric.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the MMIO bus fabric: FSM states, rw_type encodings,
// well-known slave indices and the bus data width.
package bus_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_t;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  localparam int SLV_RAM   = 0;
  localparam int SLV_GPIO  = 1;
  localparam int SLV_VGA   = 2;
  localparam int SLV_TIMER = 3;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder: top SEL_BITS select the slave, the low
// OFFS_BITS are forwarded and everything above them is zeroed.
module mmio_addr_decode
  import bus_pkg::*;
#(
  parameter int N_SLAVES  = 4,
  parameter int SEL_BITS  = 4,
  parameter int OFFS_BITS = 24
) (
  input  logic [DATA_W-1:0]   addr,
  output logic [SEL_BITS-1:0] idx,
  output logic                mapped,
  output logic [DATA_W-1:0]   offs
);

  localparam logic [DATA_W-1:0] OFFS_MASK = 32'hFFFF_FFFF >> (DATA_W - OFFS_BITS);

  assign idx    = addr[DATA_W-1:DATA_W-SEL_BITS];
  assign mapped = 32'(idx) < 32'(N_SLAVES);
  assign offs   = addr & OFFS_MASK;

endmodule

// File: rtl/mmio_bus_fabric.sv
// Request/acknowledge MMIO interconnect between the core load/store port and
// N slaves, with unmapped-address and slave-timeout bus errors.
module mmio_bus_fabric
  import bus_pkg::*;
#(
  parameter int N_SLAVES  = 4,
  parameter int SEL_BITS  = 4,
  parameter int OFFS_BITS = 24,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [DATA_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [2:0]                   m_size,
  output logic                         m_ready,
  output logic                         m_rvalid,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [N_SLAVES-1:0]          s_req,
  output logic                         s_we,
  output logic [DATA_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [2:0]                   s_size,
  input  logic [N_SLAVES-1:0]          s_ack,
  input  logic [DATA_W*N_SLAVES-1:0]   s_rdata,
  output logic [DATA_W-1:0]            err_addr
);

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_t            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_W-1:0]     addr_p0;

  logic [SEL_BITS-1:0]   dec_idx;
  logic                  dec_mapped;
  logic [DATA_W-1:0]     dec_offs;
  logic [N_SLAVES-1:0]   sel_onehot;
  logic [DATA_W-1:0]     rdata_sel;
  logic                  ack_hit;

  mmio_addr_decode #(
    .N_SLAVES  (N_SLAVES),
    .SEL_BITS  (SEL_BITS),
    .OFFS_BITS (OFFS_BITS)
  ) u_decode (
    .addr   (m_addr),
    .idx    (dec_idx),
    .mapped (dec_mapped),
    .offs   (dec_offs)
  );

  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      sel_onehot[k] = (dec_idx == SEL_BITS'(k));
    end
  end

  // s_req is one-hot on the selected slave during ACCESS, so it doubles as
  // the mask that discards acks and read data from every other slave.
  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (s_req[k]) rdata_sel = rdata_sel | s_rdata[k*DATA_W +: DATA_W];
    end
  end

  assign ack_hit = |(s_ack & s_req);
  assign m_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_p0  <= '0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
      s_req    <= '0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_size   <= '0;
      err_addr <= '0;
    end else begin
      m_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m_req) begin
            addr_p0  <= m_addr;
            s_we     <= m_we;
            s_addr   <= dec_offs;
            s_wdata  <= m_wdata;
            s_size   <= m_size;
            wait_cnt <= '0;
            if (dec_mapped) begin
              s_req <= sel_onehot;
              state <= ST_ACCESS;
            end else begin
              m_rvalid <= 1'b1;
              m_err    <= 1'b1;
              m_rdata  <= '0;
              err_addr <= m_addr;
              state    <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (ack_hit) begin
            s_req    <= '0;
            m_rvalid <= 1'b1;
            m_err    <= 1'b0;
            m_rdata  <= s_we ? '0 : rdata_sel;
            state    <= ST_RESP;
          end else if (wait_cnt == TO_LAST) begin
            s_req    <= '0;
            m_rvalid <= 1'b1;
            m_err    <= 1'b1;
            m_rdata  <= '0;
            err_addr <= addr_p0;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          m_err <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
